timer_hex_display: RTL and testbench
====================================

# timer_hex_display

Downstream display stage for the two-digit BCD countdown timer. It registers the timer's `ones_digit`/`tens_digit` and `done` outputs and drives two DE1-SoC seven-segment displays (active-low segments) with optional leading-zero blanking. On each rising edge of `done` it runs a bounded blink sequence, then returns to steady display.

## Interface

**Parameters**
- `BLINK_HALF_PERIOD`, default 25_000_000 — clock cycles per blink phase (0.5 s at 50 MHz); legal range ≥ 1.
- `BLINK_PHASES`, default 6 — number of phases (off, on, off, …) per blink sequence; legal range ≥ 1.
- `LZB`, default 1 — 1 blanks `hex1` when the tens digit is 0; 0 shows "0".

**Ports**
- `clk` in 1 — system clock; all logic on the rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state.
- `ones_digit` in 4 — BCD ones digit from the timer.
- `tens_digit` in 4 — BCD tens digit from the timer.
- `done` in 1 — timer expiry flag, level or pulse; the block acts on its rising edge.
- `hex0` out 7 — ones display, active-low; bit0=a … bit6=g.
- `hex1` out 7 — tens display, same encoding.
- `blinking` out 1 — high while a blink sequence is in progress.

## Operation

**Stage 1 (input register), every cycle**
- `ones_r` ← `ones_digit`; `tens_r` ← `tens_digit`; `done_d` ← `done`.
- `done_rise` = `done & ~done_d`, evaluated combinationally.

**Blink FSM** (states SHOW, BLINK_OFF, BLINK_ON; phase counter `pcnt` sized for BLINK_HALF_PERIOD−1; phase index `ph` sized for BLINK_PHASES)
- SHOW: on `done_rise`, go to BLINK_OFF with `pcnt`=0 and `ph`=0.
- BLINK_OFF / BLINK_ON: `pcnt` increments each cycle. When `pcnt` = BLINK_HALF_PERIOD−1:
  - reset `pcnt` to 0 and increment `ph`;
  - if `ph`+1 = BLINK_PHASES, go to SHOW;
  - otherwise toggle between OFF and ON.
- `done_rise` in either blink state restarts the sequence: BLINK_OFF, `pcnt`=0, `ph`=0. This takes priority over phase completion in the same cycle.
- `done` held high does not retrigger; only a new rising edge does.

**Decode (stage 2, registered outputs)**
- Segment codes, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - 10–15 (non-BCD) = 3F (dash, segment g only).
  - Blank = 7F.
- Tens blanking: `hex1` = 7F when `LZB`=1 and `tens_r`=0. Otherwise it shows the decoded `tens_r`, including 3F for non-BCD values.
- State SHOW or BLINK_ON: `hex0`/`hex1` take the decoded values.
- State BLINK_OFF: both outputs are 7F.
- `blinking` is registered high when the state is not SHOW.

## Timing

- Reset (asynchronous) values:
  - `hex0`=`hex1`=7F, `blinking`=0;
  - state SHOW, `pcnt`=`ph`=0;
  - `ones_r`=`tens_r`=0, `done_d`=0.
- Digit latency is 2 cycles: a change on `ones_digit`/`tens_digit` sampled at edge k appears on `hex*` after edge k+1.
- Done latency: `done` sampled high at edge k (with `done_d`=0) puts the FSM in BLINK_OFF after edge k. `hex*`=7F and `blinking`=1 after edge k+1.
- Each phase lasts exactly BLINK_HALF_PERIOD cycles. The total sequence is BLINK_PHASES × BLINK_HALF_PERIOD cycles, after which the display returns to steady with a 1-cycle output lag.
- Digits keep updating during BLINK_ON; no freeze.
- Reset asserted mid-blink: outputs go to their reset values immediately, and no blink resumes after release even if `done` is still high. `done_d` clears to 0, so a still-high `done` is seen as a rising edge on the first post-reset edge and starts a new sequence.
- Counter wrap: `pcnt` never exceeds BLINK_HALF_PERIOD−1. With BLINK_HALF_PERIOD=1 the phase toggles every cycle.

## Test plan

Benches use BLINK_HALF_PERIOD=4, BLINK_PHASES=4 unless stated otherwise.

- **Reset values:** assert `reset` asynchronously between edges → `hex0`=`hex1`=7F and `blinking`=0 immediately. Release with digits 0/0 and `LZB`=1 → 2 edges later `hex0`=40, `hex1`=7F.
- **Decode path:** tens=4, ones=2 → `hex1`=19, `hex0`=24 exactly 2 edges later. Sweep ones 0–15 → the table values, with 3F for 10–15.
- **Leading-zero blanking:** tens=0, ones=7 with `LZB`=1 → `hex1`=7F, `hex0`=78. With `LZB`=0 → `hex1`=40. Tens=11 → `hex1`=3F for both settings.
- **Blink sequence:** digits 0/0, one-cycle `done` pulse → `hex*` pattern of 7F×4, steady×4, 7F×4, steady×4. `blinking`=1 for 16 cycles, then 0. Holding `done` high afterward → no second sequence.
- **Retrigger:** second `done` rising edge during the 3rd phase → the sequence restarts with a full 16-cycle run from BLINK_OFF.
- **Reset mid-blink:** reset during BLINK_ON → immediate 7F/`blinking`=0. Release with `done` low → steady display, no blink. Release with `done` high → a new blink sequence starts.

Source files
------------

// File: rtl/timer_hex_display_if.sv
// Signal bundle between the BCD countdown timer and its seven-segment display stage.
// The timer side drives digits and the done flag; the display side drives segments.
interface timer_hex_display_if;
  logic [3:0] ones_digit;
  logic [3:0] tens_digit;
  logic       done;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic       blinking;

  modport master (
    output ones_digit,
    output tens_digit,
    output done,
    input  hex0,
    input  hex1,
    input  blinking
  );

  modport slave (
    input  ones_digit,
    input  tens_digit,
    input  done,
    output hex0,
    output hex1,
    output blinking
  );
endinterface

// File: rtl/timer_hex_display.sv
// Two-digit seven-segment display stage for the countdown timer: registered decode,
// optional tens-digit blanking, and a bounded blink sequence on each rising edge of done.
module timer_hex_display #(
  parameter int unsigned BLINK_HALF_PERIOD = 25_000_000,
  parameter int unsigned BLINK_PHASES      = 6,
  parameter bit          LZB               = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  timer_hex_display_if.slave  bus
);

  localparam int unsigned PCNT_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam int unsigned PH_W   = $clog2(BLINK_PHASES + 1);

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(BLINK_HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BLINK_PHASES - 1);
  localparam logic [6:0]        SEG_BLANK = 7'h7F;
  localparam logic [6:0]        SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    SHOW      = 2'd0,
    BLINK_OFF = 2'd1,
    BLINK_ON  = 2'd2
  } state_t;

  state_t            state;
  logic [PCNT_W-1:0] pcnt;
  logic [PH_W-1:0]   ph;

  logic [3:0] ones_r;
  logic [3:0] tens_r;
  logic       done_d;
  logic       done_rise;

  logic [3:0] digit   [2];
  logic [6:0] seg_dec [2];
  logic [6:0] tens_shown;

  logic [6:0] hex0_seg;
  logic [6:0] hex1_seg;
  logic       blinking_flag;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Stage 1: capture timer outputs; done_d gives the edge detector its history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_r <= 4'd0;
      tens_r <= 4'd0;
      done_d <= 1'b0;
    end else begin
      ones_r <= bus.ones_digit;
      tens_r <= bus.tens_digit;
      done_d <= bus.done;
    end
  end

  assign done_rise = bus.done & ~done_d;

  // A fresh done edge always restarts from BLINK_OFF, even on a phase boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SHOW;
      pcnt  <= '0;
      ph    <= '0;
    end else if (done_rise) begin
      state <= BLINK_OFF;
      pcnt  <= '0;
      ph    <= '0;
    end else begin
      case (state)
        SHOW: begin
          pcnt <= pcnt;
        end
        BLINK_OFF, BLINK_ON: begin
          if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
            ph   <= ph + PH_W'(1);
            if (ph == PH_LAST) begin
              state <= SHOW;
            end else if (state == BLINK_OFF) begin
              state <= BLINK_ON;
            end else begin
              state <= BLINK_OFF;
            end
          end else begin
            pcnt <= pcnt + PCNT_W'(1);
          end
        end
        default: begin
          state <= SHOW;
          pcnt  <= '0;
          ph    <= '0;
        end
      endcase
    end
  end

  assign digit[0] = ones_r;
  assign digit[1] = tens_r;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dec
    assign seg_dec[gi] = seg_of(digit[gi]);
  end

  assign tens_shown = (LZB && (tens_r == 4'd0)) ? SEG_BLANK : seg_dec[1];

  // Stage 2: outputs follow the FSM state, so they lag it by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex0_seg      <= SEG_BLANK;
      hex1_seg      <= SEG_BLANK;
      blinking_flag <= 1'b0;
    end else begin
      blinking_flag <= (state != SHOW);
      if (state == BLINK_OFF) begin
        hex0_seg <= SEG_BLANK;
        hex1_seg <= SEG_BLANK;
      end else begin
        hex0_seg <= seg_dec[0];
        hex1_seg <= tens_shown;
      end
    end
  end

  assign bus.hex0     = hex0_seg;
  assign bus.hex1     = hex1_seg;
  assign bus.blinking = blinking_flag;

endmodule

// File: tb/tb_timer_hex_display.sv
// Randomized and directed bench for timer_hex_display: three instances (two blanking
// settings, plus a one-cycle half period) checked every cycle against an elapsed-time model.
`timescale 1ns/1ps
module tb_timer_hex_display;

  localparam int H_A = 4;
  localparam int P_A = 4;
  localparam int H_B = 1;
  localparam int P_B = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ones  = 4'd0;
  logic [3:0] tens  = 4'd0;
  logic       done  = 1'b0;

  always #5 clk = ~clk;

  timer_hex_display_if bus_a ();
  timer_hex_display_if bus_z ();
  timer_hex_display_if bus_b ();

  assign bus_a.ones_digit = ones;
  assign bus_a.tens_digit = tens;
  assign bus_a.done       = done;
  assign bus_z.ones_digit = ones;
  assign bus_z.tens_digit = tens;
  assign bus_z.done       = done;
  assign bus_b.ones_digit = ones;
  assign bus_b.tens_digit = tens;
  assign bus_b.done       = done;

  timer_hex_display #(.BLINK_HALF_PERIOD(H_A), .BLINK_PHASES(P_A), .LZB(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  timer_hex_display #(.BLINK_HALF_PERIOD(H_A), .BLINK_PHASES(P_A), .LZB(1'b0)) dut_z (
    .clk(clk), .reset(reset), .bus(bus_z));
  timer_hex_display #(.BLINK_HALF_PERIOD(H_B), .BLINK_PHASES(P_B), .LZB(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  logic [6:0] act_hex0 [3];
  logic [6:0] act_hex1 [3];
  logic       act_blk  [3];
  assign act_hex0[0] = bus_a.hex0;  assign act_hex1[0] = bus_a.hex1;  assign act_blk[0] = bus_a.blinking;
  assign act_hex0[1] = bus_z.hex0;  assign act_hex1[1] = bus_z.hex1;  assign act_blk[1] = bus_z.blinking;
  assign act_hex0[2] = bus_b.hex0;  assign act_hex1[2] = bus_b.hex1;  assign act_blk[2] = bus_b.blinking;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Model: the blink sequence is a pure function of cycles elapsed since the latest done rise.
  int  hh [3] = '{H_A, H_A, H_B};
  int  pp [3] = '{P_A, P_A, P_B};
  bit  lz [3] = '{1'b1, 1'b0, 1'b1};

  bit  armed    = 1'b0;
  int  m_ones   = 0;
  int  m_tens   = 0;
  bit  m_done_d = 1'b0;
  bit  has_t0   = 1'b0;
  int  t0       = 0;
  int  edge_n   = 0;
  bit  prev_has = 1'b0;
  int  prev_el  = 0;
  logic [6:0] exp_hex0 [3];
  logic [6:0] exp_hex1 [3];
  logic       exp_blk  [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      armed    = 1'b1;
      m_ones   = 0;
      m_tens   = 0;
      m_done_d = 1'b0;
      has_t0   = 1'b0;
      t0       = 0;
      edge_n   = 0;
      prev_has = 1'b0;
      prev_el  = 0;
      for (int i = 0; i < 3; i++) begin
        exp_hex0[i] = 7'h7F;
        exp_hex1[i] = 7'h7F;
        exp_blk[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_blk[i] = prev_has && (prev_el < hh[i] * pp[i]);
        if (exp_blk[i] && ((prev_el / hh[i]) % 2 == 0)) begin
          exp_hex0[i] = 7'h7F;
          exp_hex1[i] = 7'h7F;
        end else begin
          exp_hex0[i] = seg(m_ones);
          exp_hex1[i] = (lz[i] && m_tens == 0) ? 7'h7F : seg(m_tens);
        end
      end
      if (done && !m_done_d) begin
        has_t0 = 1'b1;
        t0     = edge_n;
      end
      m_done_d = done;
      m_ones   = int'(ones);
      m_tens   = int'(tens);
      prev_has = has_t0;
      prev_el  = edge_n - t0;
      edge_n++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("hex0[%0d]", i), act_hex0[i], exp_hex0[i]);
        chk($sformatf("hex1[%0d]", i), act_hex1[i], exp_hex1[i]);
        chk($sformatf("blinking[%0d]", i), {6'd0, act_blk[i]}, {6'd0, exp_blk[i]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_pulse(input logic done_during);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_hex0", bus_a.hex0, 7'h7F);
    chk("rst_hex1", bus_a.hex1, 7'h7F);
    chk("rst_blinking", {6'd0, bus_a.blinking}, 7'd0);
    done = done_during;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, want finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a;
    int cnt_b;

    // Reset values, asserted between edges
    #2 reset = 1'b1;
    #1;
    chk("init_hex0", bus_a.hex0, 7'h7F);
    chk("init_hex1", bus_a.hex1, 7'h7F);
    chk("init_blinking", {6'd0, bus_a.blinking}, 7'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("post_rst_hex0", bus_a.hex0, 7'h40);
    chk("post_rst_hex1_lzb1", bus_a.hex1, 7'h7F);
    chk("post_rst_hex1_lzb0", bus_z.hex1, 7'h40);
    $display("step reset: done");

    // Decode latency: new digits show after the second edge, not the first
    tens = 4'd4; ones = 4'd2;
    tick(1);
    chk("lat1_hex0_old", bus_a.hex0, 7'h40);
    tick(1);
    chk("lat2_hex0", bus_a.hex0, 7'h24);
    chk("lat2_hex1", bus_a.hex1, 7'h19);
    for (int i = 0; i < 16; i++) begin
      ones = 4'(i);
      tick(1);
    end
    tick(2);
    chk("sweep_last_dash", bus_a.hex0, 7'h3F);
    $display("step decode sweep: done");

    // Leading-zero blanking
    tens = 4'd0; ones = 4'd7;
    tick(2);
    chk("lzb1_hex1", bus_a.hex1, 7'h7F);
    chk("lzb1_hex0", bus_a.hex0, 7'h78);
    chk("lzb0_hex1", bus_z.hex1, 7'h40);
    tens = 4'd11;
    tick(2);
    chk("tens11_lzb1", bus_a.hex1, 7'h3F);
    chk("tens11_lzb0", bus_z.hex1, 7'h3F);
    $display("step blanking: done");

    // Single blink sequence from a one-cycle pulse
    tens = 4'd0; ones = 4'd0;
    tick(2);
    done = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 24; c++) begin
      tick(1);
      if (c == 0) done = 1'b0;
      cnt_a += int'(bus_a.blinking);
      cnt_b += int'(bus_b.blinking);
      if (c >= 1 && c <= 16)
        chk($sformatf("pattern_c%0d", c), bus_a.hex0, (((c - 1) / 4) % 2 == 0) ? 7'h7F : 7'h40);
    end
    chk_int("blink_len_a", cnt_a, 16);
    chk_int("blink_len_b", cnt_b, 3);
    $display("step blink pulse: done");

    // done held high: exactly one sequence
    done = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 44; c++) begin
      tick(1);
      cnt_a += int'(bus_a.blinking);
    end
    chk_int("held_done_len", cnt_a, 16);
    done = 1'b0;
    tick(4);
    $display("step done held: done");

    // Retrigger during the third phase
    done = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (c == 0) done = 1'b0;
      if (c == 8) done = 1'b1;
      if (c == 9) done = 1'b0;
      cnt_a += int'(bus_a.blinking);
    end
    chk_int("retrigger_len", cnt_a, 25);
    $display("step retrigger: done");

    // Reset mid-blink, release with done low
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(5);
    async_reset_pulse(1'b0);
    cnt_a = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      cnt_a += int'(bus_a.blinking);
    end
    chk_int("rst_low_no_blink", cnt_a, 0);

    // Reset mid-blink, release with done high
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(5);
    async_reset_pulse(1'b1);
    cnt_a = 0;
    for (int c = 0; c < 24; c++) begin
      tick(1);
      cnt_a += int'(bus_a.blinking);
    end
    chk_int("rst_high_new_blink", cnt_a, 16);
    done = 1'b0;
    tick(2);
    $display("step reset mid-blink: done");

    // Randomized traffic, including sparse and dense done activity and async resets
    for (int blk = 0; blk < 12; blk++) begin
      int rate;
      rate = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 12 : 40);
      for (int c = 0; c < 250; c++) begin
        tick(1);
        ones = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        tens = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        if ($urandom_range(0, rate - 1) == 0) done = ~done;
        if ($urandom_range(0, 299) == 0) begin
          #2 reset = 1'b1;
          tick(1);
          reset = 1'b0;
        end
      end
      $display("step random block %0d: done", blk);
    end

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
